// File: rtl/ambi_mem_arb_pkg.sv
// Shared types and defaults for the ambi RAM arbiter: port identifiers and
// default widths / lock cap.
package ambi_mem_arb_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int LOCK_MAX_DEF = 64;

  // Bit positions in request/grant vectors
  localparam int IDX_H = 0;
  localparam int IDX_C = 1;

  typedef enum logic {
    PORT_H = 1'b0,
    PORT_C = 1'b1
  } port_e;

endpackage

// File: rtl/ambi_mem_arb_rr_arb2.sv
// Two-way round-robin arbiter with a host lock override and a starvation cap
// that forces one core grant after LOCK_MAX consecutive locked host grants.
//   state (last_q) | meaning
//   PORT_H         | host granted last, core wins next contended cycle
//   PORT_C         | core granted last, host wins next contended cycle
module ambi_mem_arb_rr_arb2
  import ambi_mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  port_e            last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_c;
  logic             lock_h;

  always_comb begin
    gnt     = 2'b00;
    force_c = (cnt_q == CNT_MAX) && req[IDX_C];
    lock_h  = lock && req[IDX_H];
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (force_c)               gnt = 2'b10;
        else if (lock_h)           gnt = 2'b01;
        else if (last_q == PORT_H) gnt = 2'b10;
        else                       gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase

    last_d = last_q;
    if (gnt[IDX_H])      last_d = PORT_H;
    else if (gnt[IDX_C]) last_d = PORT_C;

    // Counter saturates at the cap so an absent core does not wrap it
    cnt_d = cnt_q;
    if (!lock || gnt[IDX_C])
      cnt_d = '0;
    else if (gnt[IDX_H] && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_H;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ambi_mem_arb.sv
// Shares one single-port synchronous RAM between the host loader (H) and the
// ambi core memory side (C); one access per cycle, response one cycle later.
module ambi_mem_arb
  import ambi_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_vld_q, rsp_vld_d;
  port_e             rsp_own_q, rsp_own_d;
  logic              rsp_rd_q, rsp_rd_d;
  logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;

  // Requests are masked while in reset so ready and mem_en sit at reset values
  assign req = {c_valid, h_valid} & {2{rst_n}};

  ambi_mem_arb_rr_arb2 #(
    .LOCK_MAX(LOCK_MAX)
  ) u_rr_arb2 (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .lock (h_lock),
    .gnt  (gnt)
  );

  always_comb begin
    mem_en      = gnt[IDX_H] | gnt[IDX_C];
    mem_we      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt[IDX_H]) begin
      mem_we      = h_we;
      mem_addr_d  = h_addr;
      mem_wdata_d = h_wdata;
    end else if (gnt[IDX_C]) begin
      mem_we      = c_we;
      mem_addr_d  = c_addr;
      mem_wdata_d = c_wdata;
    end

    rsp_vld_d = mem_en;
    rsp_own_d = gnt[IDX_C] ? PORT_C : PORT_H;
    rsp_rd_d  = mem_en & ~mem_we;

    h_rvalid = rsp_vld_q && (rsp_own_q == PORT_H);
    c_rvalid = rsp_vld_q && (rsp_own_q == PORT_C);

    // RAM data is presented in the rvalid cycle and then held for the owner
    h_rdata_d = h_rdata_q;
    c_rdata_d = c_rdata_q;
    if (h_rvalid && rsp_rd_q) h_rdata_d = mem_rdata;
    if (c_rvalid && rsp_rd_q) c_rdata_d = mem_rdata;
  end

  assign h_ready   = gnt[IDX_H];
  assign c_ready   = gnt[IDX_C];
  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign h_rdata   = h_rdata_d;
  assign c_rdata   = c_rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_own_q   <= PORT_H;
      rsp_rd_q    <= 1'b0;
      h_rdata_q   <= '0;
      c_rdata_q   <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_own_q   <= rsp_own_d;
      rsp_rd_q    <= rsp_rd_d;
      h_rdata_q   <= h_rdata_d;
      c_rdata_q   <= c_rdata_d;
    end
  end

endmodule

// File: tb/tb_ambi_mem_arb.sv
// Directed and randomized checks of ambi_mem_arb against a behavioural model
// of the arbitration rules and a shadow copy of RAM contents.
module tb_ambi_mem_arb;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          h_valid, h_we, h_lock;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          c_valid, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          h_ready, c_ready, h_rvalid, c_rvalid;
  logic [DW-1:0] h_rdata, c_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  ambi_mem_arb #(
    .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_lock(h_lock), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM macro stand-in: synchronous, read data valid the cycle after mem_en
  logic [DW-1:0] ram [256];
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            m_last_c;
  int            m_cnt;
  bit            m_pend_vld, m_pend_c, m_pend_rd;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] exp_h_rdata, exp_c_rdata, exp_mwdata;
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_mem [256];
  bit            o_h_ready, o_c_ready;
  int            h_rsp_cnt, c_rsp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_c    = 1'b0;
    m_cnt       = 0;
    m_pend_vld  = 1'b0;
    m_pend_c    = 1'b0;
    m_pend_rd   = 1'b0;
    exp_h_rdata = '0;
    exp_c_rdata = '0;
    exp_maddr   = '0;
    exp_mwdata  = '0;
  endtask

  task automatic drive_idle();
    h_valid = 0; h_we = 0; h_lock = 0; h_addr = '0; h_wdata = '0;
    c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0;
  endtask

  task automatic check_reset();
    chk("rst_h_ready", h_ready, 0);
    chk("rst_c_ready", c_ready, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_h_rdata", h_rdata, 0);
    chk("rst_c_rdata", c_rdata, 0);
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic step();
    bit win_h, win_c, rv_h, rv_c;
    #1;
    win_h = 0;
    win_c = 0;
    if (h_valid && c_valid) begin
      if (m_cnt >= LM)   win_c = 1;
      else if (h_lock)   win_h = 1;
      else if (m_last_c) win_h = 1;
      else               win_c = 1;
    end else if (h_valid) win_h = 1;
    else if (c_valid)     win_c = 1;

    o_h_ready = h_ready;
    o_c_ready = c_ready;
    chk("h_ready", h_ready, win_h);
    chk("c_ready", c_ready, win_c);
    chk("mem_en", mem_en, win_h | win_c);
    if (win_h) begin
      chk("mem_we_h", mem_we, h_we);
      chk("mem_addr_h", mem_addr, h_addr);
      chk("mem_wdata_h", mem_wdata, h_wdata);
    end else if (win_c) begin
      chk("mem_we_c", mem_we, c_we);
      chk("mem_addr_c", mem_addr, c_addr);
      chk("mem_wdata_c", mem_wdata, c_wdata);
    end else begin
      chk("mem_addr_hold", mem_addr, exp_maddr);
      chk("mem_wdata_hold", mem_wdata, exp_mwdata);
    end

    rv_h = m_pend_vld && !m_pend_c;
    rv_c = m_pend_vld && m_pend_c;
    if (rv_h && m_pend_rd) exp_h_rdata = m_pend_data;
    if (rv_c && m_pend_rd) exp_c_rdata = m_pend_data;
    chk("h_rvalid", h_rvalid, rv_h);
    chk("c_rvalid", c_rvalid, rv_c);
    chk("h_rdata", h_rdata, exp_h_rdata);
    chk("c_rdata", c_rdata, exp_c_rdata);
    if (h_rvalid) h_rsp_cnt++;
    if (c_rvalid) c_rsp_cnt++;

    m_pend_vld = win_h | win_c;
    m_pend_c   = win_c;
    if (win_h) begin
      m_pend_rd   = !h_we;
      m_pend_data = exp_mem[h_addr];
      if (h_we) exp_mem[h_addr] = h_wdata;
      exp_maddr  = h_addr;
      exp_mwdata = h_wdata;
    end else if (win_c) begin
      m_pend_rd   = !c_we;
      m_pend_data = exp_mem[c_addr];
      if (c_we) exp_mem[c_addr] = c_wdata;
      exp_maddr  = c_addr;
      exp_mwdata = c_wdata;
    end
    if (!h_lock || win_c)           m_cnt = 0;
    else if (win_h && (m_cnt < LM)) m_cnt++;
    if (win_h)      m_last_c = 0;
    else if (win_c) m_last_c = 1;
  endtask

  task automatic tick();
    step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a]     = '0;
      exp_mem[a] = '0;
    end
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    h_rsp_cnt = 0;
    c_rsp_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Host write then read of the same address
    h_valid = 1; h_we = 1; h_addr = 8'h10; h_wdata = 16'h1234;
    tick();
    h_we = 0;
    tick();
    drive_idle();
    tick();
    chk("wr_rd_data", h_rdata, 16'h1234);

    // Contention: both ports streaming reads
    h_rsp_cnt = 0;
    c_rsp_cnt = 0;
    h_valid = 1; h_we = 0; h_addr = 8'h10;
    c_valid = 1; c_we = 0; c_addr = 8'h11;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_alt_c", o_c_ready, (i % 2 == 0));
    end
    drive_idle();
    tick();
    chk("rr_h_rsp", h_rsp_cnt, 4);
    chk("rr_c_rsp", c_rsp_cnt, 4);

    // Lock with starvation cap
    h_valid = 1; h_lock = 1; c_valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lock_seq_c", o_c_ready, (i == 4 || i == 9));
    end
    drive_idle();
    tick();

    // Pointer to H, then C write and H read of the same address together
    h_valid = 1; h_addr = 8'h30;
    tick();
    h_addr = 8'h20;
    c_valid = 1; c_we = 1; c_addr = 8'h20; c_wdata = 16'h00FF;
    tick();
    chk("ord_c_first", o_c_ready, 1);
    c_valid = 0;
    tick();
    chk("ord_h_second", o_h_ready, 1);
    drive_idle();
    tick();
    chk("ord_rdata", h_rdata, 16'h00FF);

    // Reset in the cycle after a host read grant
    h_valid = 1; h_we = 0; h_addr = 8'h10;
    step();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Idle
    for (int i = 0; i < 10; i++) tick();

    // Randomized traffic, small address range to force collisions
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) h_lock = 1'($urandom);
      if (!h_valid && ($urandom_range(3) != 0)) begin
        h_valid = 1;
        h_we    = 1'($urandom);
        h_addr  = 8'($urandom_range(15));
        h_wdata = 16'($urandom);
      end
      if (!c_valid && ($urandom_range(3) != 0)) begin
        c_valid = 1;
        c_we    = 1'($urandom);
        c_addr  = 8'($urandom_range(15));
        c_wdata = 16'($urandom);
      end
      tick();
      if (o_h_ready) h_valid = 0;
      if (o_c_ready) c_valid = 0;
    end
    drive_idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
